// File: rtl/if_else_2.sv
// if_else_2: four-input priority selector (d > c > b > default) with a combinational result y, its registered copy y_q, and the branch code br_q.
// Ports: clk, rst (sync, active-high); a, b, c, d condition/data inputs; y combinational result; y_q and br_q registered one cycle later.
// Define IF_ELSE_2_STATS_EN to add parameter CNT_W and saturating per-branch hit counters cnt_d, cnt_c, cnt_b, cnt_0.
module if_else_2
`ifdef IF_ELSE_2_STATS_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       y,
  output logic       y_q,
  output logic [1:0] br_q
`ifdef IF_ELSE_2_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_0
`endif
);
  logic [1:0] br;
  always_comb begin
    br = d ? 2'd3 : c ? 2'd2 : b ? 2'd1 : 2'd0;
    y  = d ? a : c ? b : b ? ~a : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q  <= 1'b0;
      br_q <= 2'd0;
    end else begin
      y_q  <= y;
      br_q <= br;
    end
  end
`ifdef IF_ELSE_2_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (cnt_q[br] != '1) begin
      cnt_q[br] <= cnt_q[br] + 1'b1;
    end
  end
  assign cnt_d = cnt_q[3];
  assign cnt_c = cnt_q[2];
  assign cnt_b = cnt_q[1];
  assign cnt_0 = cnt_q[0];
`endif
endmodule

// File: tb/tb_if_else_2.sv
// tb_if_else_2: directed bench for if_else_2 with a rule-level reference model and a per-cycle compare process.
module tb_if_else_2;
  localparam int CNT_W = 2;
  logic clk = 1'b0, run = 1'b0;
  logic rst = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic y, y_q;
  logic [1:0] br_q;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] exp_yq = 0, exp_br = 0;
`ifdef IF_ELSE_2_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_c, cnt_b, cnt_0;
  int exp_cnt [4] = '{0, 0, 0, 0};
  if_else_2 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .y(y), .y_q(y_q), .br_q(br_q),
    .cnt_d(cnt_d), .cnt_c(cnt_c), .cnt_b(cnt_b), .cnt_0(cnt_0)
  );
`else
  if_else_2 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .y(y), .y_q(y_q), .br_q(br_q)
  );
`endif
  always #5 if (run) clk = ~clk;
  // Branch is the index of the highest asserted bit among {d,c,b} in v = {d,c,b,a}.
  function automatic int ref_br(logic [3:0] v);
    for (int i = 3; i >= 1; i--) if (v[i]) return i;
    return 0;
  endfunction
  function automatic int ref_y(logic [3:0] v);
    int br;
    br = ref_br(v);
    if (br == 3) return int'(v[0]);
    if (br == 2) return int'(v[1]);
    if (br == 1) return int'(!v[0]);
    return 0;
  endfunction
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      exp_yq <= 0;
      exp_br <= 0;
`ifdef IF_ELSE_2_STATS_EN
      for (int i = 0; i < 4; i++) exp_cnt[i] <= 0;
`endif
    end else begin
      exp_yq <= ref_y({d, c, b, a});
      exp_br <= ref_br({d, c, b, a});
`ifdef IF_ELSE_2_STATS_EN
      if (exp_cnt[ref_br({d, c, b, a})] < (1 << CNT_W) - 1)
        exp_cnt[ref_br({d, c, b, a})] <= exp_cnt[ref_br({d, c, b, a})] + 1;
`endif
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("y_q", 32'(y_q), exp_yq);
      check("br_q", 32'(br_q), exp_br);
      check("y_comb", 32'(y), ref_y({d, c, b, a}));
`ifdef IF_ELSE_2_STATS_EN
      check("cnt_d", 32'(cnt_d), exp_cnt[3]);
      check("cnt_c", 32'(cnt_c), exp_cnt[2]);
      check("cnt_b", 32'(cnt_b), exp_cnt[1]);
      check("cnt_0", 32'(cnt_0), exp_cnt[0]);
`endif
    end
  end
  task automatic apply(logic r, logic [3:0] v);
    rst = r;
    {d, c, b, a} = v;
    @(posedge clk);
    #2;
  endtask
  logic [4:0] comb_vec [8] = '{5'b0000_0, 5'b1001_1, 5'b1110_0, 5'b1111_1,
                               5'b0101_0, 5'b0111_1, 5'b0011_0, 5'b0010_1};
  initial begin
    for (int i = 0; i < 8; i++) begin
      {d, c, b, a} = comb_vec[i][4:1];
      #10;
      check($sformatf("comb_y[%0d]", i), 32'(y), 32'(comb_vec[i][0]));
      check($sformatf("model_y[%0d]", i), ref_y(comb_vec[i][4:1]), 32'(comb_vec[i][0]));
    end
    run = 1'b1;
    @(posedge clk);
    #2;
    apply(1'b1, 4'b0000);
    apply(1'b1, 4'b0000);
    chk_en = 1'b1;
    check("rst_y_q", 32'(y_q), 0);
    check("rst_br_q", 32'(br_q), 0);
    apply(1'b0, 4'b1001);
    check("d_y_q", 32'(y_q), 1);
    check("d_br_q", 32'(br_q), 3);
    apply(1'b0, 4'b0100);
    check("c_y_q", 32'(y_q), 0);
    check("c_br_q", 32'(br_q), 2);
    apply(1'b0, 4'b1001);
    check("pre_rst_y_q", 32'(y_q), 1);
    apply(1'b1, 4'b1001);
    check("mid_rst_y_q", 32'(y_q), 0);
    check("mid_rst_br_q", 32'(br_q), 0);
    check("mid_rst_y", 32'(y), 1);
    a = 1'b0;
    #1;
    check("mid_rst_y_follow", 32'(y), 0);
    apply(1'b1, 4'b1000);
    for (int i = 0; i < 5; i++) apply(1'b0, 4'b1000);
`ifdef IF_ELSE_2_STATS_EN
    check("sat_cnt_d", 32'(cnt_d), 3);
    check("sat_cnt_c", 32'(cnt_c), 0);
    check("sat_cnt_b", 32'(cnt_b), 0);
    check("sat_cnt_0", 32'(cnt_0), 0);
`endif
    check("br3_br_q", 32'(br_q), 3);
    apply(1'b1, 4'b1000);
`ifdef IF_ELSE_2_STATS_EN
    check("clr_cnt_d", 32'(cnt_d), 0);
`endif
    check("clr_br_q", 32'(br_q), 0);
    for (int i = 0; i < 16; i++) apply(1'b0, 4'(i));
    for (int i = 15; i >= 0; i--) apply(1'b0, 4'(i));
    apply(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
